// File: rtl/umi_isolate_ctrl_pkg.sv
// Shared types for the UMI power/isolation sequencer: state encoding and
// the registered output decode used by the top-level FSM.
package umi_isolate_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_ON     = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_ISO    = 3'd2,
        ST_OFF    = 3'd3,
        ST_PWRUP  = 3'd4,
        ST_SETTLE = 3'd5
    } state_e;

    typedef struct packed {
        logic isolate;
        logic pwr_en;
        logic umi_block;
        logic pd_ack;
    } ctrl_out_t;

    localparam ctrl_out_t RESET_OUT = '{isolate: 1'b1, pwr_en: 1'b0, umi_block: 1'b1, pd_ack: 1'b1};

    function automatic ctrl_out_t decode_out(input state_e st);
        ctrl_out_t o;
        case (st)
            ST_ON:     o = '{isolate: 1'b0, pwr_en: 1'b1, umi_block: 1'b0, pd_ack: 1'b0};
            ST_DRAIN:  o = '{isolate: 1'b0, pwr_en: 1'b1, umi_block: 1'b1, pd_ack: 1'b0};
            ST_ISO,
            ST_PWRUP,
            ST_SETTLE: o = '{isolate: 1'b1, pwr_en: 1'b1, umi_block: 1'b1, pd_ack: 1'b0};
            default:   o = RESET_OUT;
        endcase
        return o;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/umi_isolate_ctrl_sync.sv
// Async-reset flop chain bringing the domain power-good into clk_i;
// resets to 0 so a reset always looks like power is not yet good.
module umi_isolate_ctrl_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = d_i;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/umi_isolate_ctrl.sv
// Power/isolation sequencer for one switchable UMI domain.
// Optional drain timeout is built when UMI_ISOLATE_CTRL_TIMEOUT_EN is defined.
//
//   state  | meaning
//   ON     | domain powered, traffic flowing
//   DRAIN  | ingress blocked, waiting for IDLE_CYCLES quiet cycles
//   ISO    | isolation applied, power still on for ISO_SETUP cycles
//   OFF    | domain unpowered and isolated (pd_ack)
//   PWRUP  | power enabled, waiting for synced power-good
//   SETTLE | power-good seen, waiting SETTLE_CYCLES before release
module umi_isolate_ctrl
    import umi_isolate_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES   = 4,
    parameter int ISO_SETUP     = 2,
    parameter int SETTLE_CYCLES = 16,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic pd_req_i,
    output logic pd_ack_o,
    input  logic pwr_good_i,
    output logic pwr_en_o,
    output logic isolate_o,
    output logic umi_block_o,
    input  logic umi_out_valid_i,
    input  logic dom_busy_i,
    output logic drain_err_o
);

    localparam int CNT_W = $clog2(max4(IDLE_CYCLES, ISO_SETUP, SETTLE_CYCLES, DRAIN_TIMEOUT)) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] IDLE_LAST   = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ISO_LAST    = CNT_W'(ISO_SETUP - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_out_t        out_q;
    logic             pwr_good_sync;
    logic             idle;

    assign idle = !umi_out_valid_i && !dom_busy_i;

    umi_isolate_ctrl_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .d_i      (pwr_good_i),
        .q_o      (pwr_good_sync)
    );

`ifdef UMI_ISOLATE_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             tmo_hit;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef UMI_ISOLATE_CTRL_TIMEOUT_EN
        tmo_hit = 1'b0;
`endif
        case (state_q)
            ST_ON: begin
                if (pd_req_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!idle) cnt_d = '0;
                // Abort outranks completion so a late cancel never isolates.
                if (!pd_req_i) begin
                    state_d = ST_ON;
                end else if (idle && cnt_q == IDLE_LAST) begin
                    state_d = ST_ISO;
`ifdef UMI_ISOLATE_CTRL_TIMEOUT_EN
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ST_ISO;
                    tmo_hit = 1'b1;
`endif
                end
            end
            ST_ISO: begin
                if (cnt_q == ISO_LAST) state_d = ST_OFF;
            end
            ST_OFF: begin
                if (!pd_req_i) state_d = ST_PWRUP;
            end
            ST_PWRUP: begin
                if (pd_req_i) begin
                    state_d = ST_OFF;
                end else if (pwr_good_sync) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!pwr_good_sync) begin
                    state_d = ST_PWRUP;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_ON;
                end
            end
            default: state_d = ST_OFF;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from the next state so they switch with the state register.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            out_q   <= RESET_OUT;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= decode_out(state_d);
        end
    end

`ifdef UMI_ISOLATE_CTRL_TIMEOUT_EN
    always_comb begin
        tmo_d = '0;
        if (state_q == ST_DRAIN && state_d == ST_DRAIN) begin
            tmo_d = (tmo_q == CNT_MAX) ? tmo_q : tmo_q + CNT_W'(1);
        end
        err_d = err_q;
        if (tmo_hit) err_d = 1'b1;
        if (state_d == ST_DRAIN && state_q != ST_DRAIN) err_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign drain_err_o = err_q;
`else
    assign drain_err_o = 1'b0;
`endif

    assign isolate_o   = out_q.isolate;
    assign pwr_en_o    = out_q.pwr_en;
    assign umi_block_o = out_q.umi_block;
    assign pd_ack_o    = out_q.pd_ack;

endmodule
